// File: rtl/fetch_unit_if.sv
// Handshake bundles used by fetch_unit: the instruction-memory fetch port
// and the port that hands instructions to the execute stage.

interface ifetch_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req_vld;
  logic          req_rdy;
  logic [AW-1:0] req_pc;
  logic          rsp_vld;
  logic          rsp_rdy;
  logic [DW-1:0] rsp_ir;

  modport master (
    output req_vld, req_pc, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_ir
  );

  modport slave (
    input  req_vld, req_pc, rsp_rdy,
    output req_rdy, rsp_vld, rsp_ir
  );
endinterface

interface iexec_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic             req_vld;
  logic             req_rdy;
  logic [DW+AW-1:0] req_pkt;   // {ir, pc}
  logic [DW:0]      rsp_pkt;   // {taken, offset}, meaningful only when the instruction is accepted

  modport master (
    output req_vld, req_pkt,
    input  req_rdy, rsp_pkt
  );

  modport slave (
    input  req_vld, req_pkt,
    output req_rdy, rsp_pkt
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, keeps at most one fetch in
// flight, buffers one returned instruction for execute, and redirects on a
// taken response from execute. Wrong-path fetches in flight at a redirect
// are marked killed and their response is drained and dropped.

module fetch_unit #(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic      clk,
  input  logic      rst,
  ifetch_if.master  ifetch,
  iexec_if.master   iexec
);

  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] flight_pc;
  logic          outst;
  logic          kill;
  logic          buf_vld;
  logic [DW-1:0] buf_ir;
  logic [AW-1:0] buf_pc;

  logic          fetch_fire;
  logic          rsp_fire;
  logic          exec_fire;
  logic          taken;
  logic          redirect;
  logic          load;
  logic [AW-1:0] offset;
  logic [AW-1:0] target;

  // Outputs are forced quiet while reset is held, even in the first reset
  // cycle when the state registers still hold pre-reset values.
  assign ifetch.req_vld = !outst && !rst;
  assign ifetch.req_pc  = rst ? RESET_PC : fetch_pc;
  assign exec_fire      = buf_vld && iexec.req_rdy && !rst;
  // A killed response is always drained; a live one only if the buffer has room.
  assign ifetch.rsp_rdy = outst && !rst && (kill || !buf_vld || exec_fire);
  assign iexec.req_vld  = buf_vld && !rst;
  assign iexec.req_pkt  = rst ? '0 : {buf_ir, buf_pc};

  assign fetch_fire = ifetch.req_vld && ifetch.req_rdy;
  assign rsp_fire   = ifetch.rsp_vld && ifetch.rsp_rdy;
  assign taken      = iexec.rsp_pkt[DW];
  assign offset     = iexec.rsp_pkt[AW-1:0];
  assign redirect   = exec_fire && taken;
  assign target     = buf_pc + offset;
  // A response arriving alongside a redirect is wrong-path and is discarded.
  assign load       = rsp_fire && !kill && !redirect;

  // Fetch PC and outstanding/kill tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      flight_pc <= RESET_PC;
      outst     <= 1'b0;
      kill      <= 1'b0;
    end else begin
      if (redirect)
        fetch_pc <= target;
      else if (fetch_fire)
        fetch_pc <= fetch_pc + AW'(4);

      if (fetch_fire)
        flight_pc <= fetch_pc;

      // fetch fire needs outst=0 and rsp fire needs outst=1, so they never coincide
      if (fetch_fire)
        outst <= 1'b1;
      else if (rsp_fire)
        outst <= 1'b0;

      if (redirect && (fetch_fire || (outst && !rsp_fire)))
        kill <= 1'b1;
      else if (rsp_fire)
        kill <= 1'b0;
    end
  end

  // One-entry instruction buffer toward execute.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_vld <= 1'b0;
      buf_ir  <= '0;
      buf_pc  <= '0;
    end else begin
      if (load) begin
        buf_vld <= 1'b1;
        buf_ir  <= ifetch.rsp_ir;
        buf_pc  <= flight_pc;
      end else if (exec_fire) begin
        buf_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Each vector drives one cycle of inputs
// after the falling edge and compares the outputs before the next rising edge.

module tb_fetch_unit;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ifetch_if #(.AW(AW), .DW(DW)) fi0 ();
  iexec_if  #(.AW(AW), .DW(DW)) xi0 ();
  ifetch_if #(.AW(AW), .DW(DW)) fi1 ();
  iexec_if  #(.AW(AW), .DW(DW)) xi1 ();

  fetch_unit #(.AW(AW), .DW(DW), .RESET_PC(32'h0000_0000)) u_main (
    .clk    (clk),
    .rst    (rst0),
    .ifetch (fi0),
    .iexec  (xi0)
  );

  fetch_unit #(.AW(AW), .DW(DW), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk    (clk),
    .rst    (rst1),
    .ifetch (fi1),
    .iexec  (xi1)
  );

  typedef struct {
    logic        rst;
    logic        f_rdy;
    logic        r_vld;
    logic [31:0] r_ir;
    logic        x_rdy;
    logic        tk;
    logic [31:0] off;
    logic        e_fvld;
    logic [31:0] e_fpc;
    logic        e_rrdy;
    logic        e_xvld;
    logic [31:0] e_xpc;
    logic [31:0] e_xir;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(logic rst, logic f_rdy, logic r_vld, logic [31:0] r_ir,
                               logic x_rdy, logic tk, logic [31:0] off,
                               logic e_fvld, logic [31:0] e_fpc, logic e_rrdy,
                               logic e_xvld, logic [31:0] e_xpc, logic [31:0] e_xir);
    vec_t v;
    v.rst = rst; v.f_rdy = f_rdy; v.r_vld = r_vld; v.r_ir = r_ir;
    v.x_rdy = x_rdy; v.tk = tk; v.off = off;
    v.e_fvld = e_fvld; v.e_fpc = e_fpc; v.e_rrdy = e_rrdy;
    v.e_xvld = e_xvld; v.e_xpc = e_xpc; v.e_xir = e_xir;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs into the selected DUT and check its outputs.
  task automatic apply(input bit sel, input vec_t v, input int idx);
    logic        a_fvld, a_rrdy, a_xvld;
    logic [31:0] a_fpc;
    logic [63:0] a_pkt;
    @(negedge clk);
    if (!sel) begin
      rst0 = v.rst;
      fi0.req_rdy = v.f_rdy; fi0.rsp_vld = v.r_vld; fi0.rsp_ir = v.r_ir;
      xi0.req_rdy = v.x_rdy; xi0.rsp_pkt = {v.tk, v.off};
    end else begin
      rst1 = v.rst;
      fi1.req_rdy = v.f_rdy; fi1.rsp_vld = v.r_vld; fi1.rsp_ir = v.r_ir;
      xi1.req_rdy = v.x_rdy; xi1.rsp_pkt = {v.tk, v.off};
    end
    #1;
    if (!sel) begin
      a_fvld = fi0.req_vld; a_fpc = fi0.req_pc; a_rrdy = fi0.rsp_rdy;
      a_xvld = xi0.req_vld; a_pkt = xi0.req_pkt;
    end else begin
      a_fvld = fi1.req_vld; a_fpc = fi1.req_pc; a_rrdy = fi1.rsp_rdy;
      a_xvld = xi1.req_vld; a_pkt = xi1.req_pkt;
    end
    chk("ifetch.req_vld", idx, 64'(a_fvld), 64'(v.e_fvld));
    chk("ifetch.req_pc",  idx, 64'(a_fpc),  64'(v.e_fpc));
    chk("ifetch.rsp_rdy", idx, 64'(a_rrdy), 64'(v.e_rrdy));
    chk("iexec.req_vld",  idx, 64'(a_xvld), 64'(v.e_xvld));
    if (v.e_xvld || v.rst)
      chk("iexec.req_pkt", idx, a_pkt, {v.e_xir, v.e_xpc});
  endtask

  initial begin
    fi0.req_rdy = 1'b0; fi0.rsp_vld = 1'b0; fi0.rsp_ir = '0;
    xi0.req_rdy = 1'b0; xi0.rsp_pkt = '0;
    fi1.req_rdy = 1'b0; fi1.rsp_vld = 1'b0; fi1.rsp_ir = '0;
    xi1.req_rdy = 1'b0; xi1.rsp_pkt = '0;

    // rst f_rdy r_vld r_ir x_rdy tk off | fvld fpc rrdy xvld xpc xir
    tbl.push_back(mkv(1,1,0,32'h0,1,0,32'h0,        0,32'h000,0,0,32'h0,32'h0));
    // sequential fetch, 1-cycle memory, one instruction every 2 cycles
    tbl.push_back(mkv(0,1,0,32'h0,1,0,32'h0,        1,32'h000,0,0,32'h0,32'h0));
    tbl.push_back(mkv(0,1,1,32'hA000_0000,1,0,32'h0,0,32'h004,1,0,32'h0,32'h0));
    tbl.push_back(mkv(0,1,0,32'h0,1,0,32'h0,        1,32'h004,0,1,32'h000,32'hA000_0000));
    tbl.push_back(mkv(0,1,1,32'hA000_0004,1,0,32'h0,0,32'h008,1,0,32'h0,32'h0));
    tbl.push_back(mkv(0,1,0,32'h0,1,0,32'h0,        1,32'h008,0,1,32'h004,32'hA000_0004));
    tbl.push_back(mkv(0,1,1,32'hA000_0008,1,0,32'h0,0,32'h00C,1,0,32'h0,32'h0));
    // taken at 0x8 (+0x20) in the same cycle as the 0xC fetch fires
    tbl.push_back(mkv(0,1,0,32'h0,1,1,32'h20,       1,32'h00C,0,1,32'h008,32'hA000_0008));
    tbl.push_back(mkv(0,1,1,32'hA000_000C,1,0,32'h0,0,32'h028,1,0,32'h0,32'h0));
    tbl.push_back(mkv(0,1,0,32'h0,1,0,32'h0,        1,32'h028,0,0,32'h0,32'h0));
    tbl.push_back(mkv(0,1,1,32'hA000_0028,1,0,32'h0,0,32'h02C,1,0,32'h0,32'h0));
    // hold 0x28 while 0x2C issues, then redirect as the 0x2C response fires
    tbl.push_back(mkv(0,1,0,32'h0,0,0,32'h0,        1,32'h02C,0,1,32'h028,32'hA000_0028));
    tbl.push_back(mkv(0,1,1,32'hA000_002C,1,1,32'h100,0,32'h030,1,1,32'h028,32'hA000_0028));
    tbl.push_back(mkv(0,0,0,32'h0,1,0,32'h0,        1,32'h128,0,0,32'h0,32'h0));
    tbl.push_back(mkv(0,1,0,32'h0,1,0,32'h0,        1,32'h128,0,0,32'h0,32'h0));
    // 2-cycle memory latency
    tbl.push_back(mkv(0,1,0,32'h0,1,0,32'h0,        0,32'h12C,1,0,32'h0,32'h0));
    tbl.push_back(mkv(0,1,1,32'hA000_0128,1,0,32'h0,0,32'h12C,1,0,32'h0,32'h0));
    // execute stalls 5 cycles with buffer full and 0x12C waiting
    tbl.push_back(mkv(0,1,0,32'h0,0,0,32'h0,        1,32'h12C,0,1,32'h128,32'hA000_0128));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mkv(0,1,1,32'hA000_012C,0,0,32'h0,0,32'h130,0,1,32'h128,32'hA000_0128));
    tbl.push_back(mkv(0,1,1,32'hA000_012C,1,0,32'h0,0,32'h130,1,1,32'h128,32'hA000_0128));
    tbl.push_back(mkv(0,0,0,32'h0,1,0,32'h0,        1,32'h130,0,1,32'h12C,32'hA000_012C));
    tbl.push_back(mkv(0,1,0,32'h0,1,0,32'h0,        1,32'h130,0,0,32'h0,32'h0));
    tbl.push_back(mkv(0,1,1,32'hA000_0130,1,0,32'h0,0,32'h134,1,0,32'h0,32'h0));
    // redirect with nothing outstanding: target visible next cycle
    tbl.push_back(mkv(0,0,0,32'h0,1,1,32'hFFFF_FFF0,1,32'h134,0,1,32'h130,32'hA000_0130));
    tbl.push_back(mkv(0,1,0,32'h0,1,0,32'h0,        1,32'h120,0,0,32'h0,32'h0));
    tbl.push_back(mkv(0,1,1,32'hA000_0120,1,0,32'h0,0,32'h124,1,0,32'h0,32'h0));
    tbl.push_back(mkv(0,1,0,32'h0,0,0,32'h0,        1,32'h124,0,1,32'h120,32'hA000_0120));
    // reset with a fetch outstanding, buffer full and a response offered
    tbl.push_back(mkv(1,1,1,32'hA000_0124,1,0,32'h0,0,32'h000,0,0,32'h0,32'h0));
    tbl.push_back(mkv(0,1,0,32'h0,1,0,32'h0,        1,32'h000,0,0,32'h0,32'h0));
    tbl.push_back(mkv(0,1,1,32'hA000_0000,1,0,32'h0,0,32'h004,1,0,32'h0,32'h0));
    tbl.push_back(mkv(0,0,0,32'h0,1,0,32'h0,        1,32'h004,0,1,32'h000,32'hA000_0000));
    tbl.push_back(mkv(0,0,0,32'h0,1,0,32'h0,        1,32'h004,0,0,32'h0,32'h0));

    foreach (tbl[i]) apply(1'b0, tbl[i], i);

    // RESET_PC near the top of the address space: sequential wrap, then
    // a forward redirect to 0x10 and a negative-offset redirect back to 0x0.
    apply(1'b1, mkv(1,1,0,32'h0,1,0,32'h0,        0,32'hFFFF_FFFC,0,0,32'h0,32'h0), 100);
    apply(1'b1, mkv(0,1,0,32'h0,1,0,32'h0,        1,32'hFFFF_FFFC,0,0,32'h0,32'h0), 101);
    apply(1'b1, mkv(0,1,1,32'h1111_0000,1,0,32'h0,0,32'h0000_0000,1,0,32'h0,32'h0), 102);
    apply(1'b1, mkv(0,1,0,32'h0,1,0,32'h0,        1,32'h0000_0000,0,1,32'hFFFF_FFFC,32'h1111_0000), 103);
    apply(1'b1, mkv(0,1,1,32'h2222_0000,1,0,32'h0,0,32'h0000_0004,1,0,32'h0,32'h0), 104);
    apply(1'b1, mkv(0,0,0,32'h0,1,1,32'h10,       1,32'h0000_0004,0,1,32'h0000_0000,32'h2222_0000), 105);
    apply(1'b1, mkv(0,1,0,32'h0,1,0,32'h0,        1,32'h0000_0010,0,0,32'h0,32'h0), 106);
    apply(1'b1, mkv(0,1,1,32'h3333_0000,1,0,32'h0,0,32'h0000_0014,1,0,32'h0,32'h0), 107);
    apply(1'b1, mkv(0,1,0,32'h0,1,1,32'hFFFF_FFF0,1,32'h0000_0014,0,1,32'h0000_0010,32'h3333_0000), 108);
    apply(1'b1, mkv(0,1,1,32'h4444_0000,1,0,32'h0,0,32'h0000_0000,1,0,32'h0,32'h0), 109);
    apply(1'b1, mkv(0,1,0,32'h0,1,0,32'h0,        1,32'h0000_0000,0,0,32'h0,32'h0), 110);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
